mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Initiator-side controller that drives one 16-word × 16-bit data-memory sub-segment on behalf of the CPU load/store path. It accepts single or burst load/store requests, sequences address, write data and a registered write clock strobe into the sub-segment, and captures read data from the sub-segment's combinational output. It sits between the processor datapath and the data memory.

Parameters:
ADDR_W, 4, sub-segment word-address width (16 words)
DATA_W, 16, data word width
LEN_W, 4, burst-length field width (beats = LEN_REQ+1, 1..16)

Ports:
CLK_MAC  input  1  system clock, rising-edge
RST_MAC  input  1  asynchronous, active-high reset
REQ_MAC  input  1  request valid; sampled only in IDLE
WE_REQ  input  1  1 = store burst, 0 = load burst
ADDR_REQ  input  ADDR_W  start word address
LEN_REQ  input  LEN_W  beats minus one
WDATA_REQ  input  DATA_W  store data for current beat; sampled when WDATA_RDY=1
WDATA_RDY  output  1  store data consumed this cycle
ACK_MAC  output  1  one-cycle pulse, request accepted
BUSY_MAC  output  1  high from acceptance through DONE
DONE_MAC  output  1  one-cycle pulse, burst complete
RDATA_OUT  output  DATA_W  captured load data
RDATA_VLD  output  1  one-cycle pulse, RDATA_OUT is new
ADDR_MEM  output  ADDR_W  word address to sub-segment
DATA_MEM  output  DATA_W  write data to sub-segment
WCLK_MEM  output  1  registered write clock to sub-segment (one rising edge per store beat)
DATA_OUT_MEM  input  DATA_W  combinational read data from sub-segment

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; beat counter and address register 0. WCLK_MEM falls to 0 without creating a rising edge.
- All outputs registered; no combinational path input→output.
- States: IDLE, W_SETUP, W_STROBE, W_RELEASE, R_SETUP, R_SAMPLE, DONE.
- IDLE: REQ_MAC=1 → latch WE_REQ, ADDR_REQ, LEN_REQ; beat counter=0; go W_SETUP (WE=1) or R_SETUP (WE=0). ACK_MAC and BUSY_MAC rise the following cycle (first SETUP cycle).
- W_SETUP (1 cycle): ADDR_MEM=current address; WDATA_RDY=1; WDATA_REQ registered into DATA_MEM at the exit edge.
- W_STROBE (1 cycle): WCLK_MEM=1; ADDR_MEM/DATA_MEM unchanged (set-up ≥1 cycle before the strobe edge).
- W_RELEASE (1 cycle): WCLK_MEM=0; ADDR_MEM/DATA_MEM held (hold ≥1 cycle). Exit: last beat → DONE; else address+1, counter+1, → W_SETUP.
- R_SETUP (1 cycle): ADDR_MEM=current address. R_SAMPLE (1 cycle): ADDR_MEM held; DATA_OUT_MEM registered into RDATA_OUT at exit edge; RDATA_VLD=1 in the following cycle. Exit: last beat → DONE; else address+1 → R_SETUP.
- Address increments modulo 2^ADDR_W (15→0 wrap); no error.
- DONE (1 cycle): DONE_MAC=1, BUSY_MAC=1; → IDLE. BUSY_MAC=0 in IDLE.
- Latency from the cycle with REQ accepted (cycle 0): store of N beats → WCLK_MEM high in cycles 3k+2 (k=0..N-1), DONE_MAC at cycle 3N+1; load of N beats → RDATA_VLD at cycles 2k+3, DONE_MAC at cycle 2N+1, coinciding with the last RDATA_VLD.
- REQ_MAC while not IDLE is ignored (no queueing); a request held high is accepted again in the IDLE cycle after DONE.
- RDATA_OUT holds its last value until the next capture; not cleared on DONE.
- DATA_MEM and ADDR_MEM hold their last values in IDLE.
- Reset mid-burst: beats whose WCLK_MEM rising edge has occurred are written; remaining beats are not; no DONE_MAC.

Test Plan:
1. Hold RST_MAC=1, then release → all outputs 0, BUSY_MAC=0; idle for 5 cycles → no WCLK_MEM edge.
2. Store, ADDR_REQ=5, LEN_REQ=0, WDATA_REQ=0xA5A5 → ACK cycle 1, WCLK_MEM high only in cycle 2 with ADDR_MEM=5, DATA_MEM=0xA5A5; DONE_MAC cycle 4. Load addr 5 → RDATA_VLD cycle 3 with 0xA5A5, DONE_MAC cycle 3.
3. Store burst, ADDR_REQ=14, LEN_REQ=3, data 0x1111/0x2222/0x3333/0x4444 → writes to 14, 15, 0, 1. Load burst at 14, LEN 3 → four RDATA_VLD pulses at cycles 3, 5, 7, 9, values in order; DONE_MAC cycle 9.
4. REQ_MAC held high through a 2-beat store → single ACK; second ACK in the first SETUP cycle after DONE_MAC+1 IDLE cycle; no extra WCLK_MEM edges.
5. Store, 4 beats at addr 0, data 0xAAAA..0xDDDD; assert RST_MAC during beat 2 W_STROBE (cycle 5) → outputs 0 immediately. Load addr 0–3 → 0xAAAA, 0xBBBB, old, old.
6. Full 16-beat store (LEN 15, data = address×0x0101) then 16-beat load → all 16 words read back correctly; store DONE at cycle 49; load DONE at cycle 33.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Initiator-side sequencer for a 16x16 data-memory sub-segment.
// Single/burst loads and stores with a registered write strobe.
module mem_access_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 4
) (
  input  logic              CLK_MAC,
  input  logic              RST_MAC,
  input  logic              REQ_MAC,
  input  logic              WE_REQ,
  input  logic [ADDR_W-1:0] ADDR_REQ,
  input  logic [LEN_W-1:0]  LEN_REQ,
  input  logic [DATA_W-1:0] WDATA_REQ,
  output logic              WDATA_RDY,
  output logic              ACK_MAC,
  output logic              BUSY_MAC,
  output logic              DONE_MAC,
  output logic [DATA_W-1:0] RDATA_OUT,
  output logic              RDATA_VLD,
  output logic [ADDR_W-1:0] ADDR_MEM,
  output logic [DATA_W-1:0] DATA_MEM,
  output logic              WCLK_MEM,
  input  logic [DATA_W-1:0] DATA_OUT_MEM
);

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_STROBE,
    W_RELEASE,
    R_SETUP,
    R_SAMPLE,
    DONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic             last;
  logic             accept;
  logic             step;

  assign last   = (cnt_q == len_q);
  assign accept = (state == IDLE) && REQ_MAC;
  assign step   = ((state == W_RELEASE) || (state == R_SAMPLE)) && !last;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if (REQ_MAC) state_n = WE_REQ ? W_SETUP : R_SETUP;
      W_SETUP:   state_n = W_STROBE;
      W_STROBE:  state_n = W_RELEASE;
      W_RELEASE: state_n = last ? DONE : W_SETUP;
      R_SETUP:   state_n = R_SAMPLE;
      R_SAMPLE:  state_n = last ? DONE : R_SETUP;
      DONE:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up
  // with the state they describe and never glitch.
  always_ff @(posedge CLK_MAC or posedge RST_MAC) begin
    if (RST_MAC) begin
      state     <= IDLE;
      ACK_MAC   <= 1'b0;
      BUSY_MAC  <= 1'b0;
      DONE_MAC  <= 1'b0;
      WDATA_RDY <= 1'b0;
      WCLK_MEM  <= 1'b0;
      RDATA_VLD <= 1'b0;
    end else begin
      state     <= state_n;
      ACK_MAC   <= accept;
      BUSY_MAC  <= (state_n != IDLE);
      DONE_MAC  <= (state_n == DONE);
      WDATA_RDY <= (state_n == W_SETUP);
      WCLK_MEM  <= (state_n == W_STROBE);
      RDATA_VLD <= (state == R_SAMPLE);
    end
  end

  always_ff @(posedge CLK_MAC or posedge RST_MAC) begin
    if (RST_MAC) begin
      len_q     <= '0;
      cnt_q     <= '0;
      ADDR_MEM  <= '0;
      DATA_MEM  <= '0;
      RDATA_OUT <= '0;
    end else begin
      if (accept) begin
        len_q    <= LEN_REQ;
        cnt_q    <= '0;
        ADDR_MEM <= ADDR_REQ;
      end else if (step) begin
        cnt_q    <= cnt_q + LEN_W'(1);
        ADDR_MEM <= ADDR_MEM + ADDR_W'(1);
      end
      if (state == W_SETUP) DATA_MEM <= WDATA_REQ;
      if (state == R_SAMPLE) RDATA_OUT <= DATA_OUT_MEM;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a behavioural
// 16x16 sub-segment and a shadow-array reference model.
module tb_mem_access_ctrl;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr_req = '0;
  logic [LW-1:0] len_req = '0;
  logic [DW-1:0] wdata_req = '0;
  logic          wdata_rdy, ack, busy, done, rvld, wclk;
  logic [DW-1:0] rdata, data_mem, dout_mem;
  logic [AW-1:0] addr_mem;

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .CLK_MAC(clk), .RST_MAC(rst), .REQ_MAC(req), .WE_REQ(we),
    .ADDR_REQ(addr_req), .LEN_REQ(len_req), .WDATA_REQ(wdata_req),
    .WDATA_RDY(wdata_rdy), .ACK_MAC(ack), .BUSY_MAC(busy),
    .DONE_MAC(done), .RDATA_OUT(rdata), .RDATA_VLD(rvld),
    .ADDR_MEM(addr_mem), .DATA_MEM(data_mem), .WCLK_MEM(wclk),
    .DATA_OUT_MEM(dout_mem)
  );

  always #5 clk = ~clk;

  // The sub-segment: writes on the strobe edge, combinational read.
  logic [DW-1:0] mem [16];
  always @(posedge wclk) mem[addr_mem] <= data_mem;
  assign dout_mem = mem[addr_mem];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { int c; logic [DW-1:0] d; } rd_t;
  wr_t           exp_wr[$];
  rd_t           exp_rd[$];
  int            exp_done[$];
  int            exp_ack[$];
  logic [DW-1:0] wq[$];
  logic [DW-1:0] dpat[$];
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] last_rd;

  int vectors = 0;
  int errs = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] want);
    vectors++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               nm, act, want, cyc);
    end
  endfunction

  function automatic void fail(string nm);
    vectors++;
    errs++;
    $display("FAIL %s: unexpected event (cycle %0d)", nm, cyc);
  endfunction

  // Data feeder: offers the next queued store word whenever asked.
  always @(negedge clk) begin
    if (!rst && wdata_rdy) begin
      if (wq.size() > 0) wdata_req = wq.pop_front();
      else fail("wdata_underflow");
    end
  end

  // Monitor: pops the scoreboard on every observable DUT event.
  logic wclk_prev = 1'b0;
  always @(negedge clk) begin
    wr_t w;
    rd_t r;
    int  t;
    if (!rst) begin
      if (wclk && !wclk_prev) begin
        if (exp_wr.size() == 0) fail("wclk_edge");
        else begin
          w = exp_wr.pop_front();
          chk("wr_cycle", cyc, w.c);
          chk("wr_addr", 32'(addr_mem), 32'(w.a));
          chk("wr_data", 32'(data_mem), 32'(w.d));
        end
      end
      if (rvld) begin
        if (exp_rd.size() == 0) fail("rdata_vld");
        else begin
          r = exp_rd.pop_front();
          chk("rd_cycle", cyc, r.c);
          chk("rd_data", 32'(rdata), 32'(r.d));
        end
      end
      if (done) begin
        if (exp_done.size() == 0) fail("done_pulse");
        else begin
          t = exp_done.pop_front();
          chk("done_cycle", cyc, t);
        end
      end
      if (ack) begin
        if (exp_ack.size() == 0) fail("ack_pulse");
        else begin
          t = exp_ack.pop_front();
          chk("ack_cycle", cyc, t);
        end
      end
    end
    wclk_prev = wclk;
  end

  function automatic logic [DW-1:0] next_data();
    if (dpat.size() > 0) return dpat.pop_front();
    return DW'($urandom);
  endfunction

  // Reference model: request semantics expressed as plain arithmetic.
  task automatic push_exp(bit w, int a, int len, int t0);
    wr_t e;
    rd_t r;
    int  ad;
    exp_ack.push_back(t0 + 1);
    for (int k = 0; k <= len; k++) begin
      ad = (a + k) % 16;
      if (w) begin
        e.c = t0 + 3 * k + 2;
        e.a = AW'(ad);
        e.d = next_data();
        wq.push_back(e.d);
        exp_wr.push_back(e);
        ref_mem[ad] = e.d;
      end else begin
        r.c = t0 + 2 * k + 3;
        r.d = ref_mem[ad];
        last_rd = r.d;
        exp_rd.push_back(r);
      end
    end
    exp_done.push_back(w ? t0 + 3 * (len + 1) + 1 : t0 + 2 * (len + 1) + 1);
  endtask

  task automatic drive(bit w, int a, int len);
    req = 1'b1;
    we = w;
    addr_req = AW'(a);
    len_req = LW'(len);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_done.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_done.size() != 0) begin
      fail("done_timeout");
      exp_done.delete();
    end
    @(negedge clk);
    chk("busy_idle", 32'(busy), 0);
    chk("left_wr", exp_wr.size(), 0);
    chk("left_rd", exp_rd.size(), 0);
    exp_wr.delete();
    exp_rd.delete();
  endtask

  task automatic do_req(bit w, int a, int len);
    int t0;
    @(negedge clk);
    t0 = cyc;
    push_exp(w, a, len, t0);
    drive(w, a, len);
    @(negedge clk);
    req = 1'b0;
    wait_idle();
    chk("addr_hold", 32'(addr_mem), (a + len) % 16);
    if (!w) chk("rdata_hold", 32'(rdata), 32'(last_rd));
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_wrdy"}, 32'(wdata_rdy), 0);
    chk({tag, "_wclk"}, 32'(wclk), 0);
    chk({tag, "_rvld"}, 32'(rvld), 0);
    chk({tag, "_addr"}, 32'(addr_mem), 0);
    chk({tag, "_dmem"}, 32'(data_mem), 0);
    chk({tag, "_rdata"}, 32'(rdata), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [DW-1:0] v;
    wr_t e;
    for (int i = 0; i < 16; i++) begin
      v = DW'($urandom);
      mem[i] <= v;
      ref_mem[i] = v;
    end
    last_rd = '0;

    // Reset and quiet idle
    repeat (3) @(negedge clk);
    #1 chk_zero("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    #1 chk_zero("rst_rel");
    repeat (5) @(negedge clk);

    // Single store/load
    dpat.push_back(16'hA5A5);
    do_req(1, 5, 0);
    do_req(0, 5, 0);

    // Wrapping burst
    for (int k = 1; k <= 4; k++) dpat.push_back(DW'(16'h1111 * k));
    do_req(1, 14, 3);
    do_req(0, 14, 3);

    // Request held through a burst: re-accepted after DONE
    @(negedge clk);
    t0 = cyc;
    push_exp(1, 9, 1, t0);
    push_exp(1, 9, 1, t0 + 8);
    drive(1, 9, 1);
    repeat (9) @(negedge clk);
    req = 1'b0;
    wait_idle();
    do_req(0, 9, 1);

    // Reset during the second strobe of a 4-beat store
    @(negedge clk);
    t0 = cyc;
    exp_ack.push_back(t0 + 1);
    for (int k = 0; k < 4; k++) begin
      v = DW'(16'hAAAA + 16'h1111 * k);
      wq.push_back(v);
      if (k < 2) begin
        e.c = t0 + 3 * k + 2;
        e.a = AW'(k);
        e.d = v;
        exp_wr.push_back(e);
        ref_mem[k] = v;
      end
    end
    drive(1, 0, 3);
    @(negedge clk);
    req = 1'b0;
    while (cyc != t0 + 5) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("mid_rst");
    chk("mid_left_wr", exp_wr.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    wq.delete();
    exp_wr.delete();
    exp_ack.delete();
    @(negedge clk);
    do_req(0, 0, 3);

    // Full-segment burst
    for (int k = 0; k < 16; k++) dpat.push_back(DW'(16'h0101 * k));
    do_req(1, 0, 15);
    do_req(0, 0, 15);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      do_req(1'($urandom_range(0, 1)), $urandom_range(0, 15),
             $urandom_range(0, 15));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    do_req(0, 0, 15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
